credit_sequencer: RTL and testbench

- Converts player start requests (keyboard F1/F2, joystick start) into a timed "insert coin, pause, press start" sequence driven into the Berzerk core's coin1/start1/start2 inputs.
- Replaces the bare combinational coin = start1|start2 so the game sees a clean coin pulse, then the matching start, with guaranteed gaps.
- Sits in the emu top between the input merge logic and the berzerk instance, on clk_sys.

---
 rtl/credit_sequencer.sv | 147 ++++++++++++++
 tb/tb_credit_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/credit_sequencer.sv
// Turns debounced player start requests into a timed coin / gap / start / holdoff
// sequence for the Berzerk core, with the direct coin button ORed into coin_out.
module credit_sequencer #(
  parameter int unsigned DEB_CYC   = 400000,
  parameter int unsigned COIN_CYC  = 2000000,
  parameter int unsigned GAP_CYC   = 4000000,
  parameter int unsigned START_CYC = 2000000,
  parameter int unsigned HOLD_CYC  = 4000000,
  parameter int unsigned CNT_W     = 24
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic req_start1,
  input  logic req_start2,
  input  logic coin_in,
  output logic coin_out,
  output logic start1_out,
  output logic start2_out,
  output logic busy
);

  typedef enum logic [2:0] {IDLE, COIN, GAP, START, HOLD} state_t;

  localparam logic [CNT_W-1:0] DEB_MAX    = CNT_W'(DEB_CYC);
  localparam logic [CNT_W-1:0] DEB_PRE    = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] COIN_LAST  = CNT_W'(COIN_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

  // bit 0: player 1, bit 1: player 2, bit 2: direct coin
  logic [2:0]       sync_a;
  logic [2:0]       sync_b;
  logic [CNT_W-1:0] deb [2];
  logic [1:0]       press;
  logic [1:0]       pend;
  logic [1:0]       accept;
  logic [1:0]       sel;
  logic [CNT_W-1:0] cnt;
  state_t           state;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {coin_in, req_start2, req_start1};
      sync_b <= sync_a;
    end
  end

  // Counter saturates at DEB_MAX, so a held button yields exactly one press.
  always_ff @(posedge clk_sys) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (reset || !sync_b[i])
        deb[i] <= '0;
      else if (deb[i] != DEB_MAX)
        deb[i] <= deb[i] + 1'b1;
    end
  end

  always_comb begin
    press = '0;
    for (int unsigned i = 0; i < 2; i++)
      press[i] = sync_b[i] && (deb[i] == DEB_PRE);
  end

  always_comb begin
    accept = '0;
    if (state == IDLE) begin
      if (pend[0])
        accept = 2'b01;
      else if (pend[1])
        accept = 2'b10;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pend       <= '0;
      sel        <= '0;
      coin_out   <= 1'b0;
      start1_out <= 1'b0;
      start2_out <= 1'b0;
      busy       <= 1'b0;
    end else begin
      coin_out   <= (state == COIN) | sync_b[2];
      start1_out <= (state == START) && (sel == 2'd1);
      start2_out <= (state == START) && (sel == 2'd2);
      busy       <= (state != IDLE);
      // A new press landing on the accept cycle stays pending.
      pend       <= press | (pend & ~accept);

      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept[0]) begin
            sel   <= 2'd1;
            state <= COIN;
          end else if (accept[1]) begin
            sel   <= 2'd2;
            state <= COIN;
          end
        end
        COIN: begin
          if (cnt == COIN_LAST) begin
            cnt   <= '0;
            state <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= START;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        START: begin
          if (cnt == START_LAST) begin
            cnt   <= '0;
            state <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_credit_sequencer.sv
// Directed bench for credit_sequencer: a timeline model of the coin/start schedule
// checked every cycle, plus hand-computed pins at key cycles.
module tb_credit_sequencer;

  localparam int DEB = 4;
  localparam int C   = 5;
  localparam int G   = 3;
  localparam int S   = 6;
  localparam int H   = 2;
  localparam int T   = C + G + S + H;
  localparam int N   = 290;

  logic clk_sys = 1'b0;
  logic reset, req_start1, req_start2, coin_in;
  logic coin_out, start1_out, start2_out, busy;

  always #5 clk_sys = ~clk_sys;

  credit_sequencer #(
    .DEB_CYC  (DEB),
    .COIN_CYC (C),
    .GAP_CYC  (G),
    .START_CYC(S),
    .HOLD_CYC (H),
    .CNT_W    (8)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .req_start1(req_start1),
    .req_start2(req_start2),
    .coin_in   (coin_in),
    .coin_out  (coin_out),
    .start1_out(start1_out),
    .start2_out(start2_out),
    .busy      (busy)
  );

  // Input levels seen by clock edge k
  bit in1 [N];
  bit in2 [N];
  bit cin [N];
  bit rst [N];

  int vectors     = 0;
  int miscompares = 0;

  typedef struct { int k; int sig; bit val; } pin_t;
  pin_t pins [19] = '{
    '{11, 0, 1'b0}, '{12, 0, 1'b1}, '{16, 0, 1'b1}, '{17, 0, 1'b0},
    '{19, 1, 1'b0}, '{20, 1, 1'b1}, '{25, 1, 1'b1}, '{26, 1, 1'b0},
    '{27, 3, 1'b1}, '{28, 3, 1'b0}, '{87, 0, 1'b1}, '{95, 2, 1'b1},
    '{142, 2, 1'b1}, '{226, 3, 1'b0}, '{233, 0, 1'b0}, '{234, 0, 1'b1},
    '{272, 0, 1'b1}, '{274, 0, 1'b0}, '{272, 3, 1'b0}
  };

  task automatic set_hi(input int which, input int from, input int len);
    for (int j = from; j < from + len; j++) begin
      case (which)
        0: in1[j] = 1'b1;
        1: in2[j] = 1'b1;
        2: cin[j] = 1'b1;
        default: rst[j] = 1'b1;
      endcase
    end
  endtask

  // A press registers at edge e when the last DEB live samples before the
  // synchroniser delay are all high, the run started there, and no reset intervened.
  function automatic bit press_at(input int e, input int which);
    int lo;
    bit v;
    lo = e - 1 - DEB;
    if (lo < 0) return 1'b0;
    for (int j = lo; j <= e - 1; j++)
      if (rst[j]) return 1'b0;
    for (int j = lo; j <= e - 2; j++) begin
      v = (which == 0) ? in1[j] : in2[j];
      if (!v) return 1'b0;
    end
    if (lo >= 1) begin
      v = (which == 0) ? in1[lo-1] : in2[lo-1];
      if (v && !rst[lo-1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input int k, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, k, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    bit active, p1, p2, in_seq, idle, a1, a2;
    bit e_coin, e_s1, e_s2, e_busy;
    int s, sel, ph;
    int rise1, rise2;
    logic prev1, prev2, act;

    set_hi(3, 0, 3);
    set_hi(0, 5, 20);
    for (int r = 0; r < 10; r++) set_hi(1, 40 + 4 * r, 3);
    set_hi(1, 80, 4);
    set_hi(0, 110, 8);
    set_hi(1, 110, 8);
    set_hi(1, 160, 6);
    set_hi(0, 166, 4);
    set_hi(0, 171, 4);
    set_hi(0, 176, 4);
    set_hi(0, 210, 50);
    set_hi(1, 218, 4);
    set_hi(3, 226, 1);
    set_hi(2, 270, 2);

    active = 1'b0; p1 = 1'b0; p2 = 1'b0; s = 0; sel = 0;
    rise1 = 0; rise2 = 0; prev1 = 1'b0; prev2 = 1'b0;

    for (int k = 0; k < N; k++) begin
      reset      = rst[k];
      req_start1 = in1[k];
      req_start2 = in2[k];
      coin_in    = cin[k];
      @(posedge clk_sys);
      #1;

      if (rst[k]) begin
        e_coin = 1'b0; e_s1 = 1'b0; e_s2 = 1'b0; e_busy = 1'b0;
        active = 1'b0; p1 = 1'b0; p2 = 1'b0; sel = 0;
      end else begin
        ph     = k - 1 - s;
        in_seq = active && ph >= 0 && ph < T;
        e_coin = (in_seq && ph < C) ||
                 (k >= 2 && cin[k-2] && !rst[k-2] && !rst[k-1]);
        e_s1   = in_seq && sel == 1 && ph >= C + G && ph < C + G + S;
        e_s2   = in_seq && sel == 2 && ph >= C + G && ph < C + G + S;
        e_busy = in_seq;
        idle   = !in_seq;
        a1 = idle && p1;
        a2 = idle && !p1 && p2;
        if (a1) begin s = k; sel = 1; active = 1'b1; end
        else if (a2) begin s = k; sel = 2; active = 1'b1; end
        p1 = press_at(k, 0) | (p1 & !a1);
        p2 = press_at(k, 1) | (p2 & !a2);
      end

      check("coin_out", k, coin_out, e_coin);
      check("start1_out", k, start1_out, e_s1);
      check("start2_out", k, start2_out, e_s2);
      check("busy", k, busy, e_busy);

      foreach (pins[i]) begin
        if (pins[i].k == k) begin
          case (pins[i].sig)
            0: act = coin_out;
            1: act = start1_out;
            2: act = start2_out;
            default: act = busy;
          endcase
          check("pin", k, act, pins[i].val);
        end
      end

      if (start1_out === 1'b1 && prev1 !== 1'b1) rise1++;
      if (start2_out === 1'b1 && prev2 !== 1'b1) rise2++;
      prev1 = start1_out;
      prev2 = start2_out;
    end

    check_int("start1_rises", rise1, 5);
    check_int("start2_rises", rise2, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
